prim_rr_onehot_sched: RTL and testbench
=======================================

Name: prim_rr_onehot_sched

Overview:
- Round-robin scheduler that shares one resource between NumReq requesters.
- Issues a registered onehot grant vector plus its binary index, and holds each grant until the owner signals completion.
- Every cycle, a onehot/enable/address consistency check runs on its own grant outputs; faults are latched as a sticky error for the alert path.
- Sits in front of shared hardened resources (key slots, mux-selected datapaths) inside security IPs.

Parameters:
- NumReq, 4, number of requesters; must be ≥ 2.
- IdxW, $clog2(NumReq), width of the grant index; derived, do not override.
- MaxHold, 0, maximum grant duration in cycles; 0 disables the timeout.
- HoldW, 8, width of the hold counter; MaxHold must be < 2**HoldW.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset; synchronous, active-high.
- req_i  input  NumReq  per-requester request level.
- done_i  input  1  current owner releases the grant this cycle.
- gnt_o  output  NumReq  onehot0 grant vector, registered.
- gnt_idx_o  output  IdxW  binary index of the granted requester, registered.
- gnt_valid_o  output  1  a grant is active (equals |gnt_o).
- err_o  output  1  sticky fault flag.
- err_cause_o  output  3  sticky cause bits: [0] onehot/consistency, [1] protocol, [2] timeout.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - gnt_o=0, gnt_idx_o=0, gnt_valid_o=0, err_o=0, err_cause_o=0.
  - state=IDLE, round-robin pointer ptr=0, hold counter=0.
  - Reset mid-grant drops the grant on the next edge, with no error.
- States: IDLE, GRANT, FAULT.
- Selection:
  - Pick the first asserted req_i[k] scanning k = ptr, ptr+1, … modulo NumReq (wrap-around).
  - ptr is updated to (k+1) mod NumReq when a grant is issued.
- IDLE:
  - If |req_i, go to GRANT next edge with gnt_o = onehot(k), gnt_idx_o = k.
  - Latency is one cycle from request to grant.
- GRANT, release (done_i=1):
  - Counts as a release only when done_i=1 and req_i[gnt_idx_o]=1.
  - If another request is pending (the owner's own req is ignored in this pick), re-grant back-to-back on the next edge with no bubble; stay in GRANT.
  - Otherwise go to IDLE with gnt_o=0.
  - The owner's own req cannot regain the grant in the release cycle; it re-competes from the next cycle.
- GRANT, protocol error:
  - Condition: req_i[gnt_idx_o]=0 while done_i=0.
  - Sets err_cause_o[1]; go to FAULT.
- GRANT, timeout:
  - The hold counter increments each GRANT cycle and clears on every new grant.
  - If MaxHold≠0 and counter == MaxHold-1 with done_i=0: set err_cause_o[2]; go to FAULT.
- done_i while in IDLE: ignored; no error.
- Consistency check, combinational on the registered outputs every cycle:
  - Checks gnt_o onehot0, gnt_valid_o == |gnt_o, and gnt_o[gnt_idx_o] == |gnt_o.
  - Any mismatch sets err_cause_o[0]; go to FAULT.
- Simultaneous faults: all applicable cause bits are set in the same edge.
- FAULT:
  - gnt_o=0, gnt_valid_o=0, gnt_idx_o=0; requests are ignored.
  - err_o = |err_cause_o, held until reset.
  - Only rst_i exits FAULT.
- Illegal state encoding forces FAULT with err_cause_o[0] set.

Decomposition:
- Package prim_rr_onehot_sched_pkg:
  - state enum (IDLE, GRANT, FAULT), sparse-encoded with Hamming distance ≥ 3.
  - Error-cause bit index constants.
- Sub-module: one prim_onehot_check instance with AddrWidth=IdxW, OneHotWidth=NumReq, AddrCheck=1, EnableCheck=1, StrictCheck=1.
  - Inputs: oh_i=gnt_o, addr_i=gnt_idx_o, en_i=gnt_valid_o.
  - Its err_o drives the [0] cause.
- Round-robin pick is a local function; no separate module.

Test Plan:
- NumReq=4, reset; req_i=4'b1010 held, pulse done_i every 3rd cycle → grants alternate idx 1, 3, 1, 3; first grant one cycle after req; no bubble between grants.
- req_i=4'b1111 with done_i every cycle → idx sequence 0, 1, 2, 3, 0 (wrap); gnt_o always onehot; err_o=0.
- Owner idx 2 drops req_i[2] with done_i=0 → next edge err_o=1, err_cause_o=3'b010, gnt_o=0; later requests ignored until rst_i.
- MaxHold=5, grant idx 0, never done → gnt_valid_o high exactly 5 cycles, then err_cause_o=3'b100, FAULT.
- Force gnt_o=4'b0110 via bench force → err_cause_o[0]=1 next edge; release force, assert rst_i one cycle → all outputs 0, grant resumes normally.
- Assert rst_i during an active grant → next edge gnt_o=0, ptr=0, err_o=0; req_i=4'b0100 then yields idx 2.

Source files
------------

// File: rtl/prim_rr_onehot_sched_pkg.sv
// Shared types for the round-robin onehot scheduler: sparse FSM encoding and
// error-cause bit positions.
package prim_rr_onehot_sched_pkg;

  // Every pair of legal codes differs in at least three bits, so a single or
  // double upset cannot turn one legal state into another.
  typedef enum logic [5:0] {
    StIdle  = 6'b000111,
    StGrant = 6'b111000,
    StFault = 6'b101101
  } sched_state_e;

  localparam int unsigned CauseW     = 3;
  localparam int unsigned ErrOnehot  = 0;
  localparam int unsigned ErrProto   = 1;
  localparam int unsigned ErrTimeout = 2;

endpackage

// File: rtl/prim_rr_onehot_sched_onehot_check.sv
// Combinational consistency check of a onehot0 select vector against its
// enable and binary address.
module prim_onehot_check #(
  parameter int unsigned AddrWidth   = 2,
  parameter int unsigned OneHotWidth = 4,
  parameter bit          AddrCheck   = 1'b1,
  parameter bit          EnableCheck = 1'b1,
  parameter bit          StrictCheck = 1'b1
) (
  input  logic [OneHotWidth-1:0] oh_i,
  input  logic [AddrWidth-1:0]   addr_i,
  input  logic                   en_i,
  output logic                   err_o
);

  logic any_set;
  logic multi_set;
  logic addr_hit;
  logic en_err;
  logic addr_err;

  always_comb begin
    any_set   = 1'b0;
    multi_set = 1'b0;
    addr_hit  = 1'b0;
    for (int i = 0; i < int'(OneHotWidth); i++) begin
      multi_set = multi_set | (any_set & oh_i[i]);
      any_set   = any_set | oh_i[i];
      addr_hit  = addr_hit | (oh_i[i] & (addr_i == AddrWidth'(i)));
    end
  end

  // Strict mode also flags an enable with no select bit set.
  assign en_err   = EnableCheck ? (StrictCheck ? (en_i != any_set) : (any_set & ~en_i)) : 1'b0;
  assign addr_err = AddrCheck ? (addr_hit != any_set) : 1'b0;
  assign err_o    = multi_set | en_err | addr_err;

endmodule

// File: rtl/prim_rr_onehot_sched.sv
// Round-robin scheduler granting one shared resource to NumReq requesters,
// with self-checking grant outputs and a sticky fault path.
module prim_rr_onehot_sched
  import prim_rr_onehot_sched_pkg::*;
#(
  parameter int unsigned NumReq  = 4,
  parameter int unsigned IdxW    = $clog2(NumReq),
  parameter int unsigned MaxHold = 0,
  parameter int unsigned HoldW   = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NumReq-1:0] req_i,
  input  logic              done_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   gnt_idx_o,
  output logic              gnt_valid_o,
  output logic              err_o,
  output logic [2:0]        err_cause_o
);

  // Handshake: a requester holds req_i high until it owns the grant and for as
  // long as it keeps it; the owner ends ownership by raising done_i for one
  // cycle while its req_i is still high. Dropping req_i without done_i is a
  // protocol fault.

  localparam logic [HoldW-1:0] HoldLast = HoldW'((MaxHold == 0) ? 0 : MaxHold - 1);

  sched_state_e      state_q, state_d;
  logic [NumReq-1:0] gnt_q, gnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              valid_q, valid_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic [2:0]        cause_q, cause_d;

  logic [IdxW:0] pick;
  logic          owner_req;
  logic          release_ok;
  logic          proto_err;
  logic          tmo_err;
  logic          chk_err;

  // Returns {found, index} of the first set bit scanning upward from ptr.
  function automatic logic [IdxW:0] rr_pick(input logic [NumReq-1:0] req,
                                            input logic [IdxW-1:0]   ptr);
    logic            found;
    logic [IdxW-1:0] idx;
    int              k;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < int'(NumReq); i++) begin
      k = (int'(ptr) + i) % int'(NumReq);
      if (!found && req[k]) begin
        found = 1'b1;
        idx   = IdxW'(k);
      end
    end
    return {found, idx};
  endfunction

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    idx_d      = idx_q;
    valid_d    = valid_q;
    ptr_d      = ptr_q;
    hold_d     = hold_q;
    cause_d    = cause_q;
    pick       = '0;
    owner_req  = req_i[idx_q];
    release_ok = 1'b0;
    proto_err  = 1'b0;
    tmo_err    = 1'b0;

    case (state_q)
      StIdle: begin
        hold_d = '0;
        if (|req_i) begin
          pick         = rr_pick(req_i, ptr_q);
          state_d      = StGrant;
          gnt_d        = '0;
          gnt_d[pick[IdxW-1:0]] = 1'b1;
          idx_d        = pick[IdxW-1:0];
          valid_d      = 1'b1;
          ptr_d        = IdxW'((int'(pick[IdxW-1:0]) + 1) % int'(NumReq));
        end
      end
      StGrant: begin
        hold_d     = hold_q + 1'b1;
        release_ok = done_i & owner_req;
        proto_err  = ~done_i & ~owner_req;
        tmo_err    = (MaxHold != 0) && (hold_q == HoldLast) && !done_i;
        if (proto_err || tmo_err) begin
          cause_d[ErrProto]   = cause_q[ErrProto] | proto_err;
          cause_d[ErrTimeout] = cause_q[ErrTimeout] | tmo_err;
          state_d = StFault;
          gnt_d   = '0;
          idx_d   = '0;
          valid_d = 1'b0;
        end else if (release_ok) begin
          // The releasing owner is masked so it cannot win its own handoff.
          pick   = rr_pick(req_i & ~gnt_q, ptr_q);
          hold_d = '0;
          gnt_d  = '0;
          if (pick[IdxW]) begin
            gnt_d[pick[IdxW-1:0]] = 1'b1;
            idx_d   = pick[IdxW-1:0];
            valid_d = 1'b1;
            ptr_d   = IdxW'((int'(pick[IdxW-1:0]) + 1) % int'(NumReq));
          end else begin
            state_d = StIdle;
            idx_d   = '0;
            valid_d = 1'b0;
          end
        end
      end
      StFault: begin
        gnt_d   = '0;
        idx_d   = '0;
        valid_d = 1'b0;
      end
      default: begin
        cause_d[ErrOnehot] = 1'b1;
        state_d = StFault;
        gnt_d   = '0;
        idx_d   = '0;
        valid_d = 1'b0;
      end
    endcase

    if (chk_err) begin
      cause_d[ErrOnehot] = 1'b1;
      state_d = StFault;
      gnt_d   = '0;
      idx_d   = '0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
      hold_q  <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      cause_q <= cause_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_idx_o   = idx_q;
  assign gnt_valid_o = valid_q;
  assign err_cause_o = cause_q;
  assign err_o       = |cause_q;

  // The checker watches the output ports themselves, not the internal flops.
  prim_onehot_check #(
    .AddrWidth   (IdxW),
    .OneHotWidth (NumReq),
    .AddrCheck   (1'b1),
    .EnableCheck (1'b1),
    .StrictCheck (1'b1)
  ) u_onehot_check (
    .oh_i   (gnt_o),
    .addr_i (gnt_idx_o),
    .en_i   (gnt_valid_o),
    .err_o  (chk_err)
  );

endmodule

// File: tb/tb_prim_rr_onehot_sched.sv
// Self-checking bench for prim_rr_onehot_sched: vector table plus hand-written
// timeout, forced-fault and reset sequences.
module tb_prim_rr_onehot_sched;

  localparam int W = 11;

  logic       clk;
  logic       rst_i;
  logic [3:0] req_i;
  logic       done_i;
  logic [3:0] gnt_o;
  logic [1:0] gnt_idx_o;
  logic       gnt_valid_o;
  logic       err_o;
  logic [2:0] err_cause_o;

  logic [3:0] req_to;
  logic       done_to;
  logic [3:0] gnt_to;
  logic [1:0] idx_to;
  logic       valid_to;
  logic       err_to;
  logic [2:0] cause_to;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       valid;
    logic       err;
    logic [2:0] cause;
  } vec_t;

  vec_t vecs[$];

  prim_rr_onehot_sched dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .done_i      (done_i),
    .gnt_o       (gnt_o),
    .gnt_idx_o   (gnt_idx_o),
    .gnt_valid_o (gnt_valid_o),
    .err_o       (err_o),
    .err_cause_o (err_cause_o)
  );

  prim_rr_onehot_sched #(.MaxHold(5)) dut_to (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_i       (req_to),
    .done_i      (done_to),
    .gnt_o       (gnt_to),
    .gnt_idx_o   (idx_to),
    .gnt_valid_o (valid_to),
    .err_o       (err_to),
    .err_cause_o (cause_to)
  );

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  function automatic vec_t v(input logic rst, input logic [3:0] req, input logic done,
                             input logic [3:0] gnt, input logic [1:0] idx, input logic valid,
                             input logic err, input logic [2:0] cause);
    vec_t r;
    r.rst = rst; r.req = req; r.done = done;
    r.gnt = gnt; r.idx = idx; r.valid = valid; r.err = err; r.cause = cause;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver: apply inputs, queue the expected registered outputs, compare after the edge.
  task automatic step(input string name, input logic rst, input logic [3:0] req,
                      input logic done, input logic [W-1:0] exp);
    logic [W-1:0] want;
    rst_i  = rst;
    req_i  = req;
    done_i = done;
    exp_q.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard queue empty", name);
    end else begin
      want = exp_q.pop_front();
      check(name, {21'd0, gnt_o, gnt_idx_o, gnt_valid_o, err_o, err_cause_o}, {21'd0, want});
    end
  endtask

  initial begin
    rst_i = 1'b1; req_i = '0; done_i = 1'b0;
    req_to = '0; done_to = 1'b0;

    // reset
    vecs.push_back(v(1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 3'b000));
    vecs.push_back(v(1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 3'b000));
    // two requesters, done every third cycle: 1,3,1,3 with no bubble
    vecs.push_back(v(1'b0, 4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, 3'b000));
    vecs.push_back(v(1'b0, 4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, 3'b000));
    vecs.push_back(v(1'b0, 4'b1010, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0, 3'b000));
    vecs.push_back(v(1'b0, 4'b1010, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0, 3'b000));
    vecs.push_back(v(1'b0, 4'b1010, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0, 3'b000));
    vecs.push_back(v(1'b0, 4'b1010, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0, 3'b000));
    vecs.push_back(v(1'b0, 4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, 3'b000));
    vecs.push_back(v(1'b0, 4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, 3'b000));
    vecs.push_back(v(1'b0, 4'b1010, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0, 3'b000));
    vecs.push_back(v(1'b0, 4'b1000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 3'b000));
    vecs.push_back(v(1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 3'b000));
    // all requesting, done every cycle: 0,1,2,3,0 wrap
    vecs.push_back(v(1'b0, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, 3'b000));
    vecs.push_back(v(1'b0, 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0, 3'b000));
    vecs.push_back(v(1'b0, 4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0, 3'b000));
    vecs.push_back(v(1'b0, 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0, 3'b000));
    vecs.push_back(v(1'b0, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, 3'b000));
    vecs.push_back(v(1'b0, 4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 3'b000));
    // owner 2 drops its request without done: protocol fault, then sticky
    vecs.push_back(v(1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, 3'b000));
    vecs.push_back(v(1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, 3'b000));
    vecs.push_back(v(1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b1, 3'b010));
    vecs.push_back(v(1'b0, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b1, 3'b010));
    vecs.push_back(v(1'b0, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b1, 3'b010));
    vecs.push_back(v(1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 3'b000));

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].req, vecs[i].done,
           {vecs[i].gnt, vecs[i].idx, vecs[i].valid, vecs[i].err, vecs[i].cause});
    end

    // Timeout: MaxHold=5 instance faults after exactly five granted cycles;
    // the default instance holds the grant indefinitely.
    check("to_reset_gnt", {28'd0, gnt_to}, 32'd0);
    for (int i = 1; i <= 8; i++) begin
      req_to  = 4'b0001;
      done_to = 1'b0;
      step($sformatf("nohold%0d", i), 1'b0, 4'b0001, 1'b0, {4'b0001, 2'd0, 1'b1, 1'b0, 3'b000});
      check($sformatf("to_valid%0d", i), {31'd0, valid_to}, (i <= 5) ? 32'd1 : 32'd0);
      check($sformatf("to_cause%0d", i), {29'd0, cause_to}, (i >= 6) ? 32'd4 : 32'd0);
      check($sformatf("to_err%0d", i), {31'd0, err_to}, (i >= 6) ? 32'd1 : 32'd0);
    end
    req_to = '0;
    step("rst_after_to", 1'b1, 4'b0000, 1'b0, {4'b0000, 2'd0, 1'b0, 1'b0, 3'b000});
    check("to_rst_cause", {29'd0, cause_to}, 32'd0);
    check("to_rst_valid", {31'd0, valid_to}, 32'd0);

    // Forced inconsistent grant vector trips the consistency check.
    rst_i = 1'b0; req_i = '0; done_i = 1'b0;
    force dut.gnt_o = 4'b0110;
    @(posedge clk);
    @(negedge clk);
    check("force_cause", {29'd0, err_cause_o}, 32'd1);
    check("force_err", {31'd0, err_o}, 32'd1);
    release dut.gnt_o;
    #1;
    check("force_gnt_cleared", {28'd0, gnt_o}, 32'd0);
    check("force_valid_cleared", {31'd0, gnt_valid_o}, 32'd0);
    step("force_rst", 1'b1, 4'b0000, 1'b0, {4'b0000, 2'd0, 1'b0, 1'b0, 3'b000});
    step("resume_idx2", 1'b0, 4'b0100, 1'b0, {4'b0100, 2'd2, 1'b1, 1'b0, 3'b000});
    step("resume_hold", 1'b0, 4'b0100, 1'b0, {4'b0100, 2'd2, 1'b1, 1'b0, 3'b000});

    // Reset mid-grant drops the grant and returns the pointer to 0.
    step("rst_midgrant", 1'b1, 4'b0100, 1'b0, {4'b0000, 2'd0, 1'b0, 1'b0, 3'b000});
    step("ptr0_pick1", 1'b0, 4'b1010, 1'b0, {4'b0010, 2'd1, 1'b1, 1'b0, 3'b000});
    step("ptr2_pick3", 1'b0, 4'b1010, 1'b1, {4'b1000, 2'd3, 1'b1, 1'b0, 3'b000});
    step("rst_again", 1'b1, 4'b1010, 1'b0, {4'b0000, 2'd0, 1'b0, 1'b0, 3'b000});
    step("after_rst_idx2", 1'b0, 4'b0100, 1'b0, {4'b0100, 2'd2, 1'b1, 1'b0, 3'b000});

    check("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
